// File: rtl/alu_pkg.sv
/*
 * +---------------------------------------------------------------------+
 * | Module   : alu_pkg                                                  |
 * | Purpose  : Shared ALU widths, opcode constants and the 64-bit       |
 * |            integer ALU evaluation function.                        |
 * | Revision : 1.0 - initial release                                    |
 * +---------------------------------------------------------------------+
 */
`default_nettype none

package alu_pkg;

    localparam int XLEN = 64;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] c_op_add  = 4'd0;
    localparam logic [OPW-1:0] c_op_sub  = 4'd1;
    localparam logic [OPW-1:0] c_op_and  = 4'd2;
    localparam logic [OPW-1:0] c_op_or   = 4'd3;
    localparam logic [OPW-1:0] c_op_xor  = 4'd4;
    localparam logic [OPW-1:0] c_op_slt  = 4'd5;
    localparam logic [OPW-1:0] c_op_sltu = 4'd6;
    localparam logic [OPW-1:0] c_op_sll  = 4'd7;
    localparam logic [OPW-1:0] c_op_srl  = 4'd8;
    localparam logic [OPW-1:0] c_op_sra  = 4'd9;
    localparam logic [OPW-1:0] c_op_addw = 4'd10;
    localparam logic [OPW-1:0] c_op_subw = 4'd11;
    localparam logic [OPW-1:0] c_op_sllw = 4'd12;
    localparam logic [OPW-1:0] c_op_srlw = 4'd13;
    localparam logic [OPW-1:0] c_op_sraw = 4'd14;

    function automatic logic [XLEN-1:0] alu_eval(
        input logic [OPW-1:0]  op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [31:0]     w;
        logic [XLEN-1:0] r;
        logic            is_w;
        w    = '0;
        r    = '0;
        is_w = 1'b0;
        case (op)
            c_op_add:  r = a + b;
            c_op_sub:  r = a - b;
            c_op_and:  r = a & b;
            c_op_or:   r = a | b;
            c_op_xor:  r = a ^ b;
            c_op_slt:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_sltu: r = {{(XLEN-1){1'b0}}, (a < b)};
            c_op_sll:  r = a << b[5:0];
            c_op_srl:  r = a >> b[5:0];
            c_op_sra:  r = $signed(a) >>> b[5:0];
            c_op_addw: begin w = a[31:0] + b[31:0];           is_w = 1'b1; end
            c_op_subw: begin w = a[31:0] - b[31:0];           is_w = 1'b1; end
            c_op_sllw: begin w = a[31:0] << b[4:0];           is_w = 1'b1; end
            c_op_srlw: begin w = a[31:0] >> b[4:0];           is_w = 1'b1; end
            c_op_sraw: begin w = $signed(a[31:0]) >>> b[4:0]; is_w = 1'b1; end
            default:   r = '0;
        endcase
        // Word ops produce 32 bits and sign-extend bit 31 into the upper half.
        if (is_w) begin
            r = {{(XLEN-32){w[31]}}, w};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
/*
 * +---------------------------------------------------------------------+
 * | Module   : rr_arbiter                                               |
 * | Purpose  : Combinational round-robin pick, searching from ptr+1.    |
 * | Revision : 1.0 - initial release                                    |
 * +---------------------------------------------------------------------+
 */
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic w_found;
    int   w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && (i == w_cand) && req[i]) begin
                    w_found   = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
/*
 * +---------------------------------------------------------------------+
 * | Module   : alu_arbiter                                              |
 * | Purpose  : Round-robin shares one 64-bit ALU via a 2-stage pipe.    |
 * |            ALU_ARB_STATS_EN enables per-requester grant counters.   |
 * | Revision : 1.0 - initial release                                    |
 * +---------------------------------------------------------------------+
 */
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*OPW-1:0]  req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [XLEN-1:0]      resp_res,
    output logic [NREQ*32-1:0]   stat_grants
);

    logic [IDW-1:0]  r_ptr;
    logic            r_s1_valid;
    logic [XLEN-1:0] r_s1_a;
    logic [XLEN-1:0] r_s1_b;
    logic [OPW-1:0]  r_s1_op;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    logic [IDW-1:0]  r_s2_id;
    logic [XLEN-1:0] r_s2_res;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic [NREQ-1:0] w_hs_vec;
    logic            w_hs;
    logic            w_s2_take;
    logic            w_s1_open;
    logic [XLEN-1:0] w_sel_a;
    logic [XLEN-1:0] w_sel_b;
    logic [OPW-1:0]  w_sel_op;
    logic [XLEN-1:0] w_alu_res;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    // S2 drain, S1->S2 move and a fresh accept can all happen in one cycle.
    assign w_s2_take = r_s1_valid & (~r_s2_valid | resp_ready);
    assign w_s1_open = ~r_s1_valid | w_s2_take;
    assign req_ready = (w_s1_open & ~rst) ? w_grant : '0;
    assign w_hs_vec  = req_valid & req_ready;
    assign w_hs      = |w_hs_vec;

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = req_a[XLEN*i +: XLEN];
                w_sel_b  = req_b[XLEN*i +: XLEN];
                w_sel_op = req_op[OPW*i +: OPW];
            end
        end
    end

    assign w_alu_res = alu_eval(r_s1_op, r_s1_a, r_s1_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= IDW'(NREQ - 1);
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_res   <= '0;
        end else begin
            if (w_hs) begin
                r_ptr      <= w_gidx;
                r_s1_valid <= 1'b1;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_s1_op    <= w_sel_op;
                r_s1_id    <= w_gidx;
            end else if (w_s2_take) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_take) begin
                r_s2_valid <= 1'b1;
                r_s2_id    <= r_s1_id;
                r_s2_res   <= w_alu_res;
            end else if (resp_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign resp_valid = r_s2_valid;
    assign resp_id    = r_s2_id;
    assign resp_res   = r_s2_res;

`ifdef ALU_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [31:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_hs_vec[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign stat_grants[32*gi +: 32] = r_cnt;
        end
    endgenerate
`else
    assign stat_grants = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
/*
 * +---------------------------------------------------------------------+
 * | Module   : tb_alu_arbiter                                           |
 * | Purpose  : Self-checking bench: directed vectors, corner sequences  |
 * |            and random traffic against a queue-based reference.      |
 * | Revision : 1.0 - initial release                                    |
 * +---------------------------------------------------------------------+
 */
`default_nettype none

module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a;
    logic [NREQ*64-1:0]   req_b;
    logic [NREQ*4-1:0]    req_op;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [63:0]          resp_res;
    logic [NREQ*32-1:0]   stat_grants;

    alu_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_res    (resp_res),
        .stat_grants (stat_grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] res;
        int          acc;
    } item_t;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    item_t           q[$];
    int              last_grant;
    int unsigned     mstat[NREQ];
    int              cyc;
    int              n_pass;
    int              n_total;
    logic [NREQ-1:0] last_hs;
    logic [NREQ-1:0] smp_ready;
    logic            smp_valid;
    logic [63:0]     smp_res;
    logic [IDW-1:0]  smp_id;
    vec_t            tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU written with signed integer types rather than bit slicing.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        int     wa;
        int     wb;
        int     w;
        int     sh6;
        int     sh5;
        sa  = a;
        sb  = b;
        wa  = a[31:0];
        wb  = b[31:0];
        sh6 = int'(b % 64);
        sh5 = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 64'd1 : 64'd0;
            4'd6:  return (a < b) ? 64'd1 : 64'd0;
            4'd7:  return a << sh6;
            4'd8:  return a >> sh6;
            4'd9:  return sa >>> sh6;
            4'd10: begin w = wa + wb;                return longint'(w); end
            4'd11: begin w = wa - wb;                return longint'(w); end
            4'd12: begin w = wa << sh5;              return longint'(w); end
            4'd13: begin w = int'(a[31:0] >> sh5);   return longint'(w); end
            4'd14: begin w = wa >>> sh5;             return longint'(w); end
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        last_grant = NREQ - 1;
        for (int i = 0; i < NREQ; i++) mstat[i] = 0;
        last_hs = '0;
    endtask

    // One clock: sample and compare at negedge, advance the model, then cross the edge.
    task automatic step();
        logic [NREQ-1:0] rexp;
        logic            vis;
        logic            found;
        int              g;
        int              c;
        @(negedge clk);
        smp_ready = req_ready;
        smp_valid = resp_valid;
        smp_res   = resp_res;
        smp_id    = resp_id;
        rexp  = '0;
        found = 1'b0;
        g     = 0;
        if (!rst && (req_valid != '0) && !((q.size() == 2) && !resp_ready)) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (last_grant + k) % NREQ;
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            rexp[g] = 1'b1;
        end
        check("req_ready", 64'(req_ready), 64'(rexp));
        vis = (q.size() > 0) && (cyc >= q[0].acc + 1);
        check("resp_valid", 64'(resp_valid), 64'(vis));
        if (vis) begin
            check("resp_id", 64'(resp_id), 64'(q[0].id));
            check("resp_res", resp_res, q[0].res);
        end
        if (rst) begin
            model_reset();
        end else begin
            if (vis && resp_ready) void'(q.pop_front());
            last_hs = rexp;
            if (found) begin
                q.push_back('{id: g, res: ref_alu(req_op[4*g +: 4], req_a[64*g +: 64], req_b[64*g +: 64]), acc: cyc + 1});
                last_grant = g;
                if (mstat[g] != 32'hFFFF_FFFF) mstat[g]++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op[4*i +: 4]  = op;
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h7FFF_FFFF;
            4: return 64'h8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check_stats(input string name);
        logic [NREQ*32-1:0] exp;
        exp = '0;
`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) exp[32*i +: 32] = mstat[i];
`endif
        check(name, 64'(stat_grants), 64'(exp));
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        cyc        = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        model_reset();

        tbl[0]  = '{4'd0,  64'd5,                  64'd7,                  64'd12};
        tbl[1]  = '{4'd10, 64'h7FFF_FFFF,          64'd1,                  64'hFFFF_FFFF_8000_0000};
        tbl[2]  = '{4'd6,  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        tbl[3]  = '{4'd15, 64'd123,                64'd456,                64'd0};
        tbl[4]  = '{4'd1,  64'd3,                  64'd5,                  64'hFFFF_FFFF_FFFF_FFFE};
        tbl[5]  = '{4'd14, 64'h8000_0000,          64'd4,                  64'hFFFF_FFFF_F800_0000};
        tbl[6]  = '{4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd1};
        tbl[7]  = '{4'd9,  64'h8000_0000_0000_0000, 64'd63,                 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[8]  = '{4'd12, 64'd1,                  64'd31,                 64'hFFFF_FFFF_8000_0000};
        tbl[9]  = '{4'd13, 64'hFFFF_FFFF,          64'd4,                  64'h0FFF_FFFF};
        tbl[10] = '{4'd7,  64'd1,                  64'd64,                 64'd1};
        tbl[11] = '{4'd8,  64'hFF00,               64'd8,                  64'hFF};
        tbl[12] = '{4'd4,  64'hF0F0,               64'hFF00,               64'h0FF0};
        tbl[13] = '{4'd3,  64'hF000,               64'h000F,               64'hF00F};
        tbl[14] = '{4'd11, 64'd0,                  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF};

        // Reset state
        @(posedge clk);
        #1;
        step();
        check("reset_resp_id", 64'(resp_id), 64'd0);
        check("reset_resp_res", resp_res, 64'd0);
        check("reset_stats", 64'(stat_grants), 64'd0);
        rst = 1'b0;

        // Directed vectors through requester 0, checking 2-cycle latency
        for (int t = 0; t < 15; t++) begin
            set_req(0, tbl[t].op, tbl[t].a, tbl[t].b);
            req_valid = 2'b01;
            step();
            check("vec_accept", 64'(smp_ready), 64'd1);
            req_valid = '0;
            step();
            step();
            check("vec_valid", 64'(smp_valid), 64'd1);
            check("vec_res", smp_res, tbl[t].exp);
        end

        // Both requesters continuously valid: strict alternation from 0
        do_reset();
        set_req(0, 4'd1, 64'd3, 64'd5);
        set_req(1, 4'd14, 64'h8000_0000, 64'd4);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("alt_grant", 64'(smp_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        req_valid = '0;
        step();
        step();

        // Backpressure: pipeline fills, then drains in order
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 4'd0, 64'd1, 64'd2);
        req_valid = 2'b01;
        step();
        set_req(0, 4'd1, 64'd10, 64'd4);
        step();
        set_req(0, 4'd4, 64'hF0, 64'hFF);
        step();
        check("full_ready", 64'(smp_ready), 64'd0);
        step();
        step();
        check("held_res", smp_res, 64'd3);
        resp_ready = 1'b1;
        step();
        check("drain0", smp_res, 64'd3);
        req_valid = '0;
        step();
        check("drain1", smp_res, 64'd6);
        step();
        check("drain2", smp_res, 64'h0F);
        step();

        // Reset mid-flight discards the accepted operation
        do_reset();
        set_req(0, 4'd10, 64'h7FFF_FFFF, 64'd1);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();
        set_req(1, 4'd0, 64'd1, 64'd1);
        req_valid = 2'b11;
        step();
        check("post_rst_first", 64'(smp_ready), 64'd1);
        req_valid = '0;
        step();
        step();

        // Grant counters: three from requester 1, one from requester 0
        do_reset();
        set_req(1, 4'd2, 64'hFF, 64'h0F);
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) step();
        req_valid = 2'b01;
        step();
        req_valid = '0;
        step();
        step();
`ifdef ALU_ARB_STATS_EN
        check("stats_3_1", 64'(stat_grants), {32'd3, 32'd1});
`else
        check("stats_off", 64'(stat_grants), 64'd0);
`endif

        // Random traffic against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !last_hs[i])) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    set_req(i, 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
                end
            end
            resp_ready = ($urandom_range(0, 9) < 7);
            if (k == 200) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check_stats("stats_random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and 2-stage pipeline sequencer that shares one 64-bit integer ALU among `NREQ` requesters (e.g. execute-stage integer path and address-generation/CSR helpers). It accepts one operation per cycle over valid/ready, registers operands, evaluates the ALU, and returns a tagged, registered result on a single response channel with backpressure.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `IDW`, 3: width of `resp_id`; must satisfy 2^IDW >= NREQ.
- `clk`  input  1  clock; all state on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_valid`  input  NREQ  per-requester operation valid.
- `req_ready`  output  NREQ  per-requester accept; handshake when valid & ready.
- `req_a`  input  NREQ*64  operand A, requester i at bits [64*i+63:64*i].
- `req_b`  input  NREQ*64  operand B, same packing.
- `req_op`  input  NREQ*4  ALU opcode, requester i at [4*i+3:4*i].
- `resp_valid`  output  1  result valid.
- `resp_ready`  input  1  consumer accepts result.
- `resp_id`  output  IDW  index of the originating requester.
- `resp_res`  output  64  ALU result.
- `stat_grants`  output  NREQ*32  per-requester accepted-operation counters (see Configuration).

## Operation
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, ADDW 10, SUBW 11, SLLW 12, SRLW 13, SRAW 14; 15 yields result 0. 64-bit shifts use b[5:0]; W-ops compute 32 bits using b[4:0] and sign-extend bit 31.
- Arbitration: combinational round-robin over `req_valid`, starting from `ptr+1` modulo NREQ; at most one `req_ready` bit high, and only when S1 can accept. `req_ready` may depend on `req_valid`.
- `ptr` updates to the granted index only on a completed request handshake; unchanged otherwise.
- S1 (operand register): holds a, b, op, id, s1_valid. S2 (result register): holds ALU(S1) result, id, s2_valid; drives `resp_*` directly.
- Advance rules: S2 loads when S1 valid and (S2 empty or `resp_ready`). S1 loads when a request handshake occurs; S1 can accept when S1 empty or S1 advances this cycle.
- Requesters hold valid and payload stable until ready; unaccepted requests are never dropped.
- In-order: responses leave in acceptance order.

## Timing
- Reset: `req_ready` 0 during rst, s1_valid/s2_valid 0, `resp_valid` 0, `resp_id` 0, `resp_res` 0, `ptr` = NREQ-1 (requester 0 wins first), counters 0.
- Latency: handshake at edge k → `resp_valid` high after edge k+1 (2 cycles accept-to-result).
- Throughput: 1 op/cycle with `resp_ready` held high; S2 drain, S1→S2 move and new accept all occur in the same cycle.
- Full: both stages valid and `resp_ready` low → all `req_ready` 0; `resp_id`/`resp_res` stable while `resp_valid & !resp_ready`.
- Reset mid-operation: in-flight S1/S2 contents discarded, no response ever emitted for them.

## Configuration
- `ALU_ARB_STATS_EN` defined: `stat_grants[i]` increments by 1 on each handshake of requester i, saturating at 0xFFFF_FFFF, cleared by rst.
- Undefined: counter logic absent; `stat_grants` tied to 0.

## Structure
- Shared package `alu_pkg`: XLEN=64, OPW=4, the 15 opcode constants above.
- Sub-module `rr_arbiter` (NREQ request bits + ptr → one-hot grant, grant index); the existing ALU datapath is instantiated between S1 and S2.

## Test plan
- req0 only: ADD a=5 b=7 → `req_ready[0]`=1 same cycle; 2 cycles later `resp_valid`=1, id 0, res 12.
- Both valid continuously, resp_ready=1: req0 SUB 3,5; req1 SRAW a=0x8000_0000 b=4 → grants 0,1,0,1…; results 0xFFFF_FFFF_FFFF_FFFE (id 0) and 0xFFFF_FFFF_F800_0000 (id 1), one per cycle.
- Backpressure: resp_ready=0 after two accepts → third request sees `req_ready`=0, resp held stable; resp_ready=1 → three results drain in order on consecutive cycles.
- Reset mid-flight: accept ADDW 0x7FFF_FFFF+1, assert rst next cycle → no response; after reset, simultaneous req0/req1 → req0 granted first.
- Edge ops: ADDW 0x7FFF_FFFF+1 → 0xFFFF_FFFF_8000_0000; SLTU 1 vs 0xFFFF…FFFF → 1; op 15 → 0.
- With `ALU_ARB_STATS_EN`: 3 accepts from req1, 1 from req0 → `stat_grants` = {3,1}; without macro → all 0.
